// File: rtl/exp_table_scheduler.sv
// Round-robin scheduler that shares one exp(x*sigma) table generator among
// N_REQ requesters and streams each sweep into the winner's table RAM bank.
module exp_table_scheduler #(
   parameter int N_REQ      = 4,
   parameter int BANK_BITS  = 2,
   parameter int PATH_WIDTH = 10,
   parameter int X_MIN      = -307,
   parameter int X_MAX      = 280,
   parameter int QUIET      = 32
) (
   input  logic                            CLK,
   input  logic                            RST,
   input  logic [N_REQ-1:0]                iReq,
   input  logic [18*N_REQ-1:0]             iSigma,
   output logic [N_REQ-1:0]                oAck,
   output logic                            oErr,
   output logic [N_REQ-1:0]                oBankValid,
   output logic                            oBusy,
   output logic [17:0]                     oGenSigma,
   output logic                            oGenStart,
   input  logic [17:0]                     iGenData,
   input  logic [PATH_WIDTH-1:0]           iGenAddr,
   input  logic                            iGenValid,
   input  logic                            iGenDone,
   output logic                            oWrEn,
   output logic [BANK_BITS+PATH_WIDTH-1:0] oWrAddr,
   output logic [17:0]                     oWrData
);

   localparam logic [2:0] S_QUIET  = 3'd0;
   localparam logic [2:0] S_IDLE   = 3'd1;
   localparam logic [2:0] S_LAUNCH = 3'd2;
   localparam logic [2:0] S_RUN    = 3'd3;
   localparam logic [2:0] S_ACK    = 3'd4;

   localparam int QW = $clog2(QUIET + 1);
   localparam logic [PATH_WIDTH-1:0] N_SAMPLES = PATH_WIDTH'(X_MAX - X_MIN);
   localparam logic [PATH_WIDTH-1:0] ADDR_BIAS = PATH_WIDTH'(X_MIN);

   logic [2:0]                      state_q, state_d;
   logic [QW-1:0]                   quiet_q, quiet_d;
   logic [BANK_BITS-1:0]            ptr_q, ptr_d;
   logic [BANK_BITS-1:0]            grant_q, grant_d;
   logic [PATH_WIDTH-1:0]           cnt_q, cnt_d;
   logic [17:0]                     sigma_q, sigma_d;
   logic [N_REQ-1:0]                bank_valid_q, bank_valid_d;
   logic                            ign_q, ign_d;
   logic                            busy_q, busy_d;
   logic                            wr_en_q, wr_en_d;
   logic [BANK_BITS+PATH_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [17:0]                     wr_data_q, wr_data_d;

   logic [N_REQ-1:0]     req_eff;
   logic                 pick_found;
   logic [BANK_BITS-1:0] pick_idx;
   logic                 count_bad;

   // The just-acked requester is masked for the ACK cycle and the IDLE cycle
   // after it, so a level request left high is taken as a fresh request.
   always_comb begin
      logic [BANK_BITS-1:0] idx;
      idx        = '0;
      req_eff    = iReq;
      if (ign_q) req_eff[grant_q] = 1'b0;
      pick_found = 1'b0;
      pick_idx   = ptr_q;
      // Scan downward so the last hit is the nearest one at or above ptr_q.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = ptr_q + BANK_BITS'(k);
         if (req_eff[idx]) begin
            pick_found = 1'b1;
            pick_idx   = idx;
         end
      end
   end

   assign count_bad = (cnt_q != N_SAMPLES);

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path through
      // the case statement can leave one unassigned and infer a latch.
      state_d      = state_q;
      quiet_d      = quiet_q;
      ptr_d        = ptr_q;
      grant_d      = grant_q;
      cnt_d        = cnt_q;
      sigma_d      = sigma_q;
      bank_valid_d = bank_valid_q;
      ign_d        = 1'b0;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;

      case (state_q)
         S_QUIET: begin
            if (iGenValid || iGenDone) begin
               quiet_d = '0;
            end else if (quiet_q == QW'(QUIET - 1)) begin
               quiet_d = '0;
               state_d = S_IDLE;
            end else begin
               quiet_d = quiet_q + QW'(1);
            end
         end
         S_IDLE: begin
            if (pick_found) begin
               grant_d                = pick_idx;
               sigma_d                = iSigma[18*pick_idx +: 18];
               bank_valid_d[pick_idx] = 1'b0;
               cnt_d                  = '0;
               state_d                = S_LAUNCH;
            end
         end
         S_LAUNCH: state_d = S_RUN;
         S_RUN: begin
            if (iGenValid) begin
               wr_en_d   = 1'b1;
               wr_data_d = iGenData;
               wr_addr_d = {grant_q, iGenAddr - ADDR_BIAS};
               if (cnt_q != {PATH_WIDTH{1'b1}}) cnt_d = cnt_q + PATH_WIDTH'(1);
            end
            if (iGenDone) state_d = S_ACK;
         end
         S_ACK: begin
            bank_valid_d[grant_q] = ~count_bad;
            ptr_d                 = grant_q + BANK_BITS'(1);
            ign_d                 = 1'b1;
            state_d               = S_IDLE;
         end
         default: state_d = S_QUIET;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= S_QUIET;
         quiet_q      <= '0;
         ptr_q        <= '0;
         grant_q      <= '0;
         cnt_q        <= '0;
         sigma_q      <= '0;
         bank_valid_q <= '0;
         ign_q        <= 1'b0;
         busy_q       <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
      end else begin
         state_q      <= state_d;
         quiet_q      <= quiet_d;
         ptr_q        <= ptr_d;
         grant_q      <= grant_d;
         cnt_q        <= cnt_d;
         sigma_q      <= sigma_d;
         bank_valid_q <= bank_valid_d;
         ign_q        <= ign_d;
         busy_q       <= busy_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
      end
   end

   always_comb begin
      oAck = '0;
      if (state_q == S_ACK) oAck[grant_q] = 1'b1;
   end

   assign oErr       = (state_q == S_ACK) && count_bad;
   assign oGenStart  = (state_q == S_LAUNCH);
   assign oBankValid = bank_valid_q;
   assign oBusy      = busy_q;
   assign oGenSigma  = sigma_q;
   assign oWrEn      = wr_en_q;
   assign oWrAddr    = wr_addr_q;
   assign oWrData    = wr_data_q;

endmodule

// File: doc/exp_table_scheduler.md
Name: exp_table_scheduler

Overview:
- Shares one exp(x*sigma) table generator among N_REQ requesters (one per risk factor / sigma).
- Round-robin arbitrates requests, latches the winner's sigma, pulses generator start, and streams generator output into that requester's bank of a shared table RAM.
- Acks the requester with a sample-count check.
- Sits between the per-factor sigma sources and the table RAM read by the risk datapath.

Parameters:
N_REQ, 4, number of requesters/banks (power of 2)
BANK_BITS, 2, log2(N_REQ)
PATH_WIDTH, 10, generator address width (signed x)
X_MIN, -307, first x of the generator sweep
X_MAX, 280, generator terminal x; samples per table = X_MAX - X_MIN (587)
QUIET, 32, consecutive idle cycles needed after reset before arbitration (> generator pipeline depth 13)

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
iReq  in  N_REQ  level request per requester
iSigma  in  18*N_REQ  sigma per requester, 18 fraction bits; slice i = bits [18i+17:18i]
oAck  out  N_REQ  one-cycle pulse when requester's table is complete
oErr  out  1  valid with oAck: 1 = sample count mismatch
oBankValid  out  N_REQ  bank holds a complete, error-free table
oBusy  out  1  high in every state except IDLE
oGenSigma  out  18  sigma to generator, held constant for the whole run
oGenStart  out  1  start pulse to generator
iGenData  in  18  generator sample (3 int, 15 frac)
iGenAddr  in  PATH_WIDTH  generator x (signed)
iGenValid  in  1  generator sample valid
iGenDone  in  1  generator sweep complete pulse
oWrEn  out  1  table RAM write enable
oWrAddr  out  BANK_BITS+PATH_WIDTH  {bank, iGenAddr - X_MIN}
oWrData  out  18  table RAM write data

Behaviour:
- Clock is CLK. Reset is synchronous, active-high, on RST.
- Reset values: all outputs 0, oGenSigma 0, state QUIET, quiet counter 0, RR pointer 0, sample counter 0.
- Reset mid-run does not stop the generator. Its outputs are ignored until QUIET completes; oWrEn stays 0.
- QUIET:
  - Counter increments while iGenValid=0 and iGenDone=0; clears to 0 otherwise.
  - At count QUIET-1, go to IDLE.
- IDLE:
  - If any iReq is set, pick the first set bit scanning from the RR pointer upward, with wrap.
  - Latch grant index g and oGenSigma <= iSigma slice g.
  - Clear oBankValid[g] and the sample counter; go to LAUNCH.
- LAUNCH: oGenStart=1 for exactly this one cycle; go to RUN.
- RUN, per cycle with iGenValid=1:
  - Next cycle: oWrEn=1, oWrData=iGenData, oWrAddr={g, (iGenAddr - X_MIN) mod 2^PATH_WIDTH}.
  - Sample counter increments (saturating at 2^PATH_WIDTH-1).
- RUN, on iGenDone=1:
  - Go to ACK.
  - If iGenValid and iGenDone are high together, the sample is written and counted before the ACK decision.
- ACK, one cycle:
  - oAck[g]=1; oErr=1 iff count != X_MAX - X_MIN.
  - oBankValid[g] <= ~oErr.
  - RR pointer <= g+1 mod N_REQ; go to IDLE.
- iReq[g] is ignored in the ACK cycle and the following IDLE cycle. A request still high after that is a new request.
- iReq and iSigma changes during LAUNCH/RUN/ACK have no effect. oGenSigma is stable from LAUNCH until the next grant.
- iGenValid/iGenDone in IDLE are ignored: no write, no state change.
- Latency, grant to last write: 2 cycles (IDLE→LAUNCH) + generator sweep + 1 registered write cycle. The ACK cycle follows the last write.

Test Plan:
- Reset, then generator idle for 32 cycles; iReq=0001, sigma0=0x08000. Expect:
  - oGenStart pulse 1 cycle after grant; oGenSigma=0x08000.
  - 587 writes at oWrAddr 0..586 in bank 0.
  - oAck=0001, oErr=0, oBankValid=0001.
- iReq=1111 held continuously with distinct sigmas. Expect grant order 0,1,2,3,0; each ack on its own bank; no write ever crosses banks.
- Reset asserted mid-run: generator model keeps streaming 300 more valids, then done. Expect:
  - No oWrEn after reset.
  - QUIET exits exactly 32 cycles after last generator activity, then normal arbitration.
- Model drops one valid sample. Expect oAck with oErr=1 and oBankValid[g]=0; next request still served.
- iGenValid and iGenDone coincident on the final sample. Expect the sample written, count 587, oErr=0.
- iSigma[g] toggled every cycle during RUN. Expect oGenSigma constant; written data matches the latched sigma.
